// File: rtl/st_pattern_checker_sink.sv
// st_pattern_checker_sink: Avalon-ST sink with programmable backpressure and incrementing per-lane pattern checker.
// Define ST_SINK_LFSR_BP_EN to drive backpressure from a 16-bit LFSR instead of the periodic phase counter.
module st_pattern_checker_sink #(
  parameter int DATA_WIDTH = 256,
  parameter int LANE_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int BP_PERIOD  = 8,
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  clear,
  input  logic                  bp_en,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky,
  output logic [CNT_WIDTH-1:0]  first_err_beat,
  output logic [NUM_LANES-1:0]  first_err_mask,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SEED, RUN, FAIL} state_t;
  state_t state, state_nxt;
  logic acc, miss;
  logic s1_v;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [LANE_WIDTH-1:0] s1_base, nb, base_now;
  logic [CNT_WIDTH-1:0]  s1_idx;
  logic [NUM_LANES-1:0]  mask;
  assign acc      = valid & ready;
  assign base_now = (state == IDLE) ? st_data[LANE_WIDTH-1:0] : nb;
  assign miss     = s1_v & (|mask);
  assign busy     = state != IDLE;
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign mask[i] = s1_data[i*LANE_WIDTH +: LANE_WIDTH] != s1_base + LANE_WIDTH'(i);
    end
  endgenerate
  always_comb begin
    state_nxt = state;
    if (clear) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = acc ? SEED : IDLE;
    else if (miss) state_nxt = FAIL;
    else if (state == SEED) state_nxt = RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v           <= 1'b0;
      s1_data        <= '0;
      s1_base        <= '0;
      s1_idx         <= '0;
      nb             <= '0;
      beat_count     <= '0;
      err_count      <= '0;
      err_sticky     <= 1'b0;
      first_err_beat <= '0;
      first_err_mask <= '0;
    end else if (clear) begin
      s1_v           <= 1'b0;
      beat_count     <= '0;
      err_count      <= '0;
      err_sticky     <= 1'b0;
      first_err_beat <= '0;
      first_err_mask <= '0;
    end else begin
      s1_v <= acc;
      if (acc) begin
        s1_data    <= st_data;
        s1_base    <= base_now;
        s1_idx     <= beat_count;
        nb         <= base_now + LANE_WIDTH'(NUM_LANES);
        beat_count <= (&beat_count) ? beat_count : beat_count + CNT_WIDTH'(1);
      end
      if (miss) begin
        err_count  <= (&err_count) ? err_count : err_count + CNT_WIDTH'(1);
        err_sticky <= 1'b1;
        if (!err_sticky) begin
          first_err_beat <= s1_idx;
          first_err_mask <= mask;
        end
      end
    end
`ifdef ST_SINK_LFSR_BP_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr  <= 16'hACE1;
      ready <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      ready <= ~bp_en | (|lfsr[1:0]);
    end
`else
  localparam int PW = $clog2(BP_PERIOD);
  logic [PW-1:0] phase, phase_nxt;
  assign phase_nxt = (phase == PW'(BP_PERIOD - 1)) ? '0 : phase + PW'(1);
  // ready is registered, so it is computed from the phase it will sit alongside
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      ready <= 1'b0;
    end else begin
      phase <= phase_nxt;
      ready <= ~bp_en | (phase_nxt != PW'(BP_PERIOD - 1));
    end
`endif
endmodule

// File: tb/tb_st_pattern_checker_sink.sv
// tb_st_pattern_checker_sink: directed vector table plus hand-written corner sequences.
module tb_st_pattern_checker_sink;
  logic clk = 0, rst_n = 0, valid = 0, clear = 0, bp_en = 0;
  logic [255:0] st_data = '0;
  logic ready, err_sticky, busy;
  logic [31:0] beat_count, err_count, first_err_beat;
  logic [7:0] first_err_mask;
  int total = 0, passed = 0, low_seen = 0;
  logic mon = 0;

  st_pattern_checker_sink #(.BP_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .st_data(st_data), .valid(valid), .ready(ready),
    .clear(clear), .bp_en(bp_en), .beat_count(beat_count), .err_count(err_count),
    .err_sticky(err_sticky), .first_err_beat(first_err_beat),
    .first_err_mask(first_err_mask), .busy(busy));

  always #5 clk = ~clk;
  always @(negedge clk) if (mon && !ready) low_seen++;

  typedef struct {
    logic [31:0] seed;
    int n, bad_beat, bad_lane;
    logic [31:0] e_beats, e_errs;
    logic e_sticky;
    logic [31:0] e_first;
    logic [7:0] e_mask;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] pat(input logic [31:0] seed, input int k, input int bad);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) begin
      d[i*32 +: 32] = seed + 32'(k * 8 + i);
      if (i == bad) d[i*32] = ~d[i*32];
    end
    return d;
  endfunction

  task automatic send(input logic [255:0] d);
    logic a;
    st_data = d;
    valid = 1;
    for (int t = 0; t < 16; t++) begin
      a = ready;
      @(negedge clk);
      if (a) return;
    end
    total++;
    $display("FAIL send_timeout: no accept within 16 cycles");
  endtask

  task automatic idle(input int n);
    valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    valid = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    int k, lows, last;
    logic sp_bad;
    vecs[0] = '{32'h100,      16, -1, -1, 16, 0, 0, 0, 8'h00};
    vecs[1] = '{32'h2000,      8,  5,  3,  8, 1, 1, 5, 8'h08};
    vecs[2] = '{32'hFFFFFFF8,  3, -1, -1,  3, 0, 0, 0, 8'h00};
    vecs[3] = '{32'h0,         6,  0,  7,  6, 1, 1, 0, 8'h80};

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", ready, 1);

    mon = 1;
    for (int v = 0; v < 4; v++) begin
      do_clear();
      for (int b = 0; b < vecs[v].n; b++)
        send(pat(vecs[v].seed, b, b == vecs[v].bad_beat ? vecs[v].bad_lane : -1));
      idle(3);
      chk($sformatf("v%0d_beat_count", v), beat_count, vecs[v].e_beats);
      chk($sformatf("v%0d_err_count", v), err_count, vecs[v].e_errs);
      chk($sformatf("v%0d_err_sticky", v), err_sticky, vecs[v].e_sticky);
      chk($sformatf("v%0d_first_err_beat", v), first_err_beat, vecs[v].e_first);
      chk($sformatf("v%0d_first_err_mask", v), first_err_mask, vecs[v].e_mask);
      chk($sformatf("v%0d_busy", v), busy, 1);
    end
    mon = 0;
    chk("ready_never_low_bp_off", low_seen, 0);

    // error latency: beat_count one edge after accept, error outputs one edge later
    do_clear();
    for (int b = 0; b < 6; b++) send(pat(32'h5555, b, b == 5 ? 3 : -1));
    valid = 0;
    chk("lat_beat_count", beat_count, 6);
    chk("lat_err_early", err_count, 0);
    @(negedge clk);
    chk("lat_err_count", err_count, 1);
    chk("lat_first_beat", first_err_beat, 5);
    chk("lat_first_mask", first_err_mask, 8'h08);

    // periodic backpressure
    bp_en = 1;
    do_clear();
    idle(2);
    k = 0; lows = 0; last = -1; sp_bad = 0;
    for (int c = 0; c < 40; c++) begin
      st_data = pat(32'h3000, k, -1);
      valid = 1;
      if (!ready) begin
        lows++;
        if (last >= 0 && c - last != 4) sp_bad = 1;
        last = c;
      end else k++;
      @(negedge clk);
    end
    idle(3);
    chk("bp_low_cycles", lows, 10);
    chk("bp_spacing", sp_bad, 0);
    chk("bp_beat_count", beat_count, 30);
    chk("bp_err_count", err_count, 0);
    bp_en = 0;
    idle(2);

    // clear coincident with the 7th accept
    do_clear();
    for (int b = 0; b < 6; b++) send(pat(32'h500, b, -1));
    clear = 1;
    st_data = pat(32'h500, 6, -1);
    valid = 1;
    @(negedge clk);
    clear = 0;
    valid = 0;
    chk("clr_beat_count", beat_count, 0);
    chk("clr_busy", busy, 0);
    for (int b = 0; b < 4; b++) send(pat(32'h40, b, -1));
    idle(3);
    chk("clr_new_beats", beat_count, 4);
    chk("clr_new_errs", err_count, 0);
    chk("clr_new_sticky", err_sticky, 0);

    // async reset mid-burst
    do_clear();
    for (int b = 0; b < 3; b++) send(pat(32'h700, b, b == 1 ? 2 : -1));
    chk("pre_rst_sticky", err_sticky, 1);
    st_data = pat(32'h700, 3, -1);
    valid = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_beat_count", beat_count, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_mask", first_err_mask, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    valid = 0;
    rst_n = 1;
    for (int b = 0; b < 4; b++) send(pat(32'h900, b, -1));
    idle(3);
    chk("post_rst_beats", beat_count, 4);
    chk("post_rst_errs", err_count, 0);
    chk("post_rst_sticky", err_sticky, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
